// File: rtl/pe_bitvert_accum_pkg.sv
// Shared constants, FSM state type and sign-extension helper for the bit-vertical PE.
package bitvert_pkg;

    localparam int ACT_WIDTH  = 8;
    localparam int VEC_LENGTH = 8;
    localparam int NUM_SEL    = 4;
    localparam int W_BITS     = 8;
    localparam int SEL_WIDTH  = 3;
    localparam int PSUM_WIDTH = 11;
    localparam int ACC_WIDTH  = 20;
    localparam int CNT_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } pe_state_t;

    function automatic logic [PSUM_WIDTH-1:0] sext_act(input logic [ACT_WIDTH-1:0] a);
        return {{(PSUM_WIDTH-ACT_WIDTH){a[ACT_WIDTH-1]}}, a};
    endfunction

endpackage

// File: rtl/pe_bitvert_accum_if.sv
// Tile load, bit-plane and result handshake bundle between scheduler/consumer and the PE.
interface pe_bitvert_accum_if;
    import bitvert_pkg::*;

    logic                                  act_load;
    logic [VEC_LENGTH-1:0][ACT_WIDTH-1:0]  act_in;
    logic                                  act_ready;
    logic                                  plane_valid;
    logic [NUM_SEL-1:0][SEL_WIDTH-1:0]     sel;
    logic [NUM_SEL-1:0]                    val;
    logic                                  inv;
    logic [ACC_WIDTH-1:0]                  result;
    logic                                  result_valid;
    logic                                  result_ready;
    logic                                  plane_err;

    modport master (
        output act_load, act_in, plane_valid, sel, val, inv, result_ready,
        input  act_ready, result, result_valid, plane_err
    );

    modport slave (
        input  act_load, act_in, plane_valid, sel, val, inv, result_ready,
        output act_ready, result, result_valid, plane_err
    );

endinterface

// File: rtl/pe_bitvert_accum_plane_sum.sv
// Combinational partial sum of one bit plane: gated lane mux, adder, optional invert (A - S).
// No state; the caller registers psum.
module bitvert_plane_sum
    import bitvert_pkg::*;
(
    input  logic [VEC_LENGTH-1:0][ACT_WIDTH-1:0] act,
    input  logic [PSUM_WIDTH-1:0]                asum,
    input  logic [NUM_SEL-1:0][SEL_WIDTH-1:0]    sel,
    input  logic [NUM_SEL-1:0]                   val,
    input  logic                                 inv,
    output logic [PSUM_WIDTH-1:0]                psum
);

    logic [PSUM_WIDTH-1:0] sel_sum;

    always_comb begin
        sel_sum = '0;
        for (int k = 0; k < NUM_SEL; k++) begin
            if (val[k]) begin
                sel_sum = sel_sum + sext_act(act[sel[k]]);
            end
        end
        // Inverted mask: the plane's set bits are every lane except the selected ones.
        psum = inv ? (asum - sel_sum) : sel_sum;
    end

endmodule

// File: rtl/pe_bitvert_accum.sv
// Bit-serial dot-product PE: 8 weight planes MSB first, shift-accumulated into a signed result.
// result_valid rises 2 edges after the 8th plane; result held until result_ready, act_load may overlap release.
module pe_bitvert_accum
    import bitvert_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    pe_bitvert_accum_if.slave    pe
);

    localparam logic [CNT_WIDTH-1:0] W_BITS_C = CNT_WIDTH'(W_BITS);

    pe_state_t                            state_q, state_d;
    logic [CNT_WIDTH-1:0]                 in_cnt_q, in_cnt_d;
    logic [CNT_WIDTH-1:0]                 out_cnt_q, out_cnt_d;
    logic [ACC_WIDTH-1:0]                 acc_q, acc_d;
    logic [VEC_LENGTH-1:0][ACT_WIDTH-1:0] act_q, act_d;
    logic [PSUM_WIDTH-1:0]                asum_q, asum_d;
    logic [PSUM_WIDTH-1:0]                p_q, p_d;
    logic                                 p_vld_q, p_vld_d;
    logic [ACC_WIDTH-1:0]                 result_q, result_d;
    logic                                 plane_err_q, plane_err_d;

    logic                  act_ready;
    logic                  load;
    logic                  plane_acc;
    logic [PSUM_WIDTH-1:0] psum;
    logic [PSUM_WIDTH-1:0] load_sum;
    logic [ACC_WIDTH-1:0]  p_ext;

    bitvert_plane_sum u_plane_sum (
        .act  (act_q),
        .asum (asum_q),
        .sel  (pe.sel),
        .val  (pe.val),
        .inv  (pe.inv),
        .psum (psum)
    );

    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        acc_d       = acc_q;
        act_d       = act_q;
        asum_d      = asum_q;
        p_d         = p_q;
        p_vld_d     = 1'b0;
        result_d    = result_q;
        plane_err_d = plane_err_q;

        load_sum = '0;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            load_sum = load_sum + sext_act(pe.act_in[i]);
        end
        p_ext = {{(ACC_WIDTH-PSUM_WIDTH){p_q[PSUM_WIDTH-1]}}, p_q};

        act_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && pe.result_ready);
        load      = pe.act_load && act_ready;
        plane_acc = (state_q == ST_ACCUM) && pe.plane_valid && (in_cnt_q < W_BITS_C);

        if (pe.plane_valid && !plane_acc) begin
            plane_err_d = 1'b1;
        end

        if (plane_acc) begin
            p_d      = psum;
            p_vld_d  = 1'b1;
            in_cnt_d = in_cnt_q + 1'b1;
        end

        // First plane carries the weight sign bit, so it enters negated.
        if (p_vld_q) begin
            if (out_cnt_q == '0) begin
                acc_d = -p_ext;
            end else begin
                acc_d = {acc_q[ACC_WIDTH-2:0], 1'b0} + p_ext;
            end
            out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: ;
            ST_ACCUM: begin
                if (out_cnt_q == W_BITS_C) begin
                    state_d  = ST_HOLD;
                    result_d = acc_q;
                end
            end
            ST_HOLD: begin
                if (pe.result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d   = ST_ACCUM;
            act_d     = pe.act_in;
            asum_d    = load_sum;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            acc_d     = '0;
            p_vld_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            acc_q       <= '0;
            act_q       <= '0;
            asum_q      <= '0;
            p_q         <= '0;
            p_vld_q     <= 1'b0;
            result_q    <= '0;
            plane_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            acc_q       <= acc_d;
            act_q       <= act_d;
            asum_q      <= asum_d;
            p_q         <= p_d;
            p_vld_q     <= p_vld_d;
            result_q    <= result_d;
            plane_err_q <= plane_err_d;
        end
    end

    assign pe.act_ready    = act_ready;
    assign pe.result       = result_q;
    assign pe.result_valid = (state_q == ST_HOLD);
    assign pe.plane_err    = plane_err_q;

endmodule

// File: tb/tb_pe_bitvert_accum.sv
// Directed bench for pe_bitvert_accum: tiles A/B/C, backpressure, back-to-back load, reset mid-tile.
module tb_pe_bitvert_accum;
    import bitvert_pkg::*;

    localparam logic [ACC_WIDTH-1:0] EXP_M16 = 20'hFFFF0;  // -16
    localparam logic [ACC_WIDTH-1:0] EXP_M35 = 20'hFFFDD;  // -35

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pe_bitvert_accum_if bus ();

    pe_bitvert_accum dut (
        .clk   (clk),
        .reset (reset),
        .pe    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_plane(input logic [11:0] s, input logic [3:0] v, input logic i);
        bus.plane_valid = 1'b1;
        bus.sel         = s;
        bus.val         = v;
        bus.inv         = i;
        tick();
        bus.plane_valid = 1'b0;
        bus.val         = '0;
        bus.inv         = 1'b0;
    endtask

    task automatic load_tile(input logic [63:0] acts);
        bus.act_load = 1'b1;
        bus.act_in   = acts;
        tick();
        bus.act_load = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [ACC_WIDTH-1:0] exp);
        int n;
        n = 0;
        while (bus.result_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (bus.result_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: result_valid=%b want 1", name, bus.result_valid);
        end
        checks++;
        if (bus.result !== exp) begin
            errors++;
            $display("FAIL %s_result: got %0d want %0d", name, $signed(bus.result), $signed(exp));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (bus.act_ready !== 1'b1) begin
            errors++; $display("FAIL rst_act_ready: got %b want 1", bus.act_ready);
        end
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL rst_result_valid: got %b want 0", bus.result_valid);
        end
        checks++;
        if (bus.result !== '0) begin
            errors++; $display("FAIL rst_result: got %0d want 0", $signed(bus.result));
        end
        checks++;
        if (bus.plane_err !== 1'b0) begin
            errors++; $display("FAIL rst_plane_err: got %b want 0", bus.plane_err);
        end
    endtask

    task automatic test_tile_a(input string name);
        load_tile({8{8'd2}});
        for (int p = 0; p < W_BITS; p++) begin
            send_plane(12'h000, 4'b0000, 1'b1);
        end
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL %s_lat0: result_valid=%b want 0", name, bus.result_valid);
        end
        tick();
        checks++;
        if (bus.result_valid !== 1'b0) begin
            errors++; $display("FAIL %s_lat1: result_valid=%b want 0", name, bus.result_valid);
        end
        tick();
        checks++;
        if (bus.result_valid !== 1'b1) begin
            errors++; $display("FAIL %s_lat2: result_valid=%b want 1", name, bus.result_valid);
        end
        checks++;
        if (bus.result !== EXP_M16) begin
            errors++; $display("FAIL %s_result: got %0d want -16", name, $signed(bus.result));
        end
    endtask

    task automatic test_backpressure();
        bus.result_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                send_plane(12'h000, 4'b1111, 1'b0);
            end else begin
                tick();
            end
            checks++;
            if (bus.result !== EXP_M16 || bus.result_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold_c%0d: result=%0d valid=%b want -16 valid 1",
                         c, $signed(bus.result), bus.result_valid);
            end
            checks++;
            if (bus.act_ready !== 1'b0) begin
                errors++; $display("FAIL bp_act_ready_c%0d: got %b want 0", c, bus.act_ready);
            end
        end
        checks++;
        if (bus.plane_err !== 1'b1) begin
            errors++; $display("FAIL bp_plane_err: got %b want 1", bus.plane_err);
        end
        bus.result_ready = 1'b1;
        #1;
        checks++;
        if (bus.act_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b want 1", bus.act_ready);
        end
        tick();
        bus.result_ready = 1'b0;
        #1;
        checks++;
        if (bus.result_valid !== 1'b0 || bus.act_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle: valid=%b act_ready=%b want 0 1", bus.result_valid, bus.act_ready);
        end
        checks++;
        if (bus.result !== EXP_M16) begin
            errors++; $display("FAIL bp_result_kept: got %0d want -16", $signed(bus.result));
        end
    endtask

    task automatic test_tile_c();
        load_tile({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
        for (int p = 0; p < W_BITS; p++) begin
            send_plane({3'd6, 3'd4, 3'd2, 3'd0}, 4'b1111, 1'b0);
        end
        wait_result("tile_c", EXP_M16);
    endtask

    task automatic test_back_to_back();
        bus.result_ready = 1'b1;
        bus.act_load     = 1'b1;
        bus.act_in       = {8'h00, 8'h00, 8'h00, 8'h00, 8'hF9, 8'h00, 8'h00, 8'h00};
        #1;
        checks++;
        if (bus.act_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_act_ready: got %b want 1", bus.act_ready);
        end
        tick();
        bus.act_load     = 1'b0;
        bus.result_ready = 1'b0;
        #1;
        checks++;
        if (bus.result_valid !== 1'b0 || bus.act_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accum: valid=%b act_ready=%b want 0 0", bus.result_valid, bus.act_ready);
        end
        for (int p = W_BITS - 1; p >= 0; p--) begin
            if (p == 2 || p == 0) begin
                send_plane({3'd0, 3'd0, 3'd0, 3'd3}, 4'b0001, 1'b0);
            end else begin
                send_plane({3'd5, 3'd5, 3'd5, 3'd5}, 4'b0000, 1'b0);
            end
        end
        wait_result("tile_b", EXP_M35);
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset_mid_tile();
        load_tile({8{8'd2}});
        for (int p = 0; p < 4; p++) begin
            send_plane(12'h000, 4'b0000, 1'b1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.act_ready !== 1'b1 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: act_ready=%b valid=%b want 1 0", bus.act_ready, bus.result_valid);
        end
        checks++;
        if (bus.result !== '0 || bus.plane_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outs: result=%0d plane_err=%b want 0 0",
                     $signed(bus.result), bus.plane_err);
        end
        test_tile_a("tile_a_post_rst");
        bus.result_ready = 1'b1;
        tick();
        bus.result_ready = 1'b0;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        reset            = 1'b1;
        bus.act_load     = 1'b0;
        bus.act_in       = '0;
        bus.plane_valid  = 1'b0;
        bus.sel          = '0;
        bus.val          = '0;
        bus.inv          = 1'b0;
        bus.result_ready = 1'b0;

        test_reset();
        test_tile_a("tile_a");
        test_backpressure();
        test_tile_c();
        test_back_to_back();
        test_reset_mid_tile();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
